// File: rtl/jtkcpu_pkg.sv
// jtkcpu_pkg: shared types for the jtkcpu bus responder.
//   region_t - address decode result (internal RAM, external window, unmapped)
//   state_t  - responder FSM encoding
//   OPEN_BUS - value returned for unmapped reads and aborted fetches
//   tag_match - read-cache hit test
package jtkcpu_pkg;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_EXT  = 2'd1,
    REG_NONE = 2'd2
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXTWAIT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [7:0] OPEN_BUS = 8'hFF;
  localparam int         TMO_W    = 8;

  // A cache entry only hits when it is valid and holds exactly this address.
  function automatic logic tag_match(input logic vld, input logic [23:0] tag,
                                     input logic [23:0] a);
    return vld && (tag == a);
  endfunction

endpackage

// File: rtl/jtkcpu_busresp_ram.sv
// jtkcpu_busresp_ram: single-port synchronous byte RAM, 2^AW x 8.
//   clk  - clock
//   we   - write enable, din stored at addr on the clock edge
//   re   - read enable, q loads mem[addr] on the clock edge (held otherwise)
//   addr - byte address
//   din  - write data
//   q    - registered read data
module jtkcpu_busresp_ram #(
  parameter int AW = 11
)(
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    q
);

  logic [7:0] mem_r [0:(1<<AW)-1];

  // Byte write port; storage has no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= din;
    end
  end

  // Registered read port; q only moves on a read so it keeps the last read byte.
  always_ff @(posedge clk) begin
    if (re) begin
      q <= mem_r[addr];
    end
  end

endmodule

// File: rtl/jtkcpu_busresp.sv
// jtkcpu_busresp: memory-bus responder for the jtkcpu core.
//   clk, rst           - clock, synchronous active-high reset
//   cen                - CPU bus-cycle enable, sampled only when idle
//   addr, we, cpu_dout - CPU address, write enable and write data
//   cpu_din, dtack     - read data to the CPU and data acknowledge (low = stall)
//   ext_addr/cs/we/din - request to the external memory controller
//   ext_dout, ext_ok   - external read data and one-cycle completion pulse
//   unmapped, timeout  - one-cycle event pulses
// Decode: internal RAM (zero wait), external window (req/ok handshake with a
// one-entry read cache and write-through), everything else unmapped.
module jtkcpu_busresp #(
  parameter int          RAM_AW    = 11,
  parameter logic [23:0] RAM_START = 24'h000000,
  parameter int          EXT_AW    = 20,
  parameter logic [23:0] EXT_START = 24'h100000,
  parameter int          TIMEOUT   = 255
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic [23:0]       addr,
  input  logic              we,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic              dtack,
  output logic [EXT_AW-1:0] ext_addr,
  output logic              ext_cs,
  output logic              ext_we,
  output logic [7:0]        ext_din,
  input  logic [7:0]        ext_dout,
  input  logic              ext_ok,
  output logic              unmapped,
  output logic              timeout
);

  import jtkcpu_pkg::*;

  // Last counter value before the abort: ext_cs is held for exactly TIMEOUT cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t            state_r, state_s;
  region_t           region_s;
  logic [7:0]        din_r, din_s;
  logic              sel_ram_r, sel_ram_s;
  logic              dtack_r, dtack_s;
  logic              ext_cs_r, ext_cs_s;
  logic              ext_we_r, ext_we_s;
  logic [EXT_AW-1:0] ext_addr_r, ext_addr_s;
  logic [7:0]        ext_din_r, ext_din_s;
  logic              unmapped_r, unmapped_s;
  logic              timeout_r, timeout_s;
  logic [TMO_W-1:0]  cnt_r, cnt_s;
  logic              cache_vld_r, cache_vld_s;
  logic [23:0]       cache_tag_r, cache_tag_s;
  logic [7:0]        cache_data_r, cache_data_s;
  logic              cache_hit_s;
  logic              ram_we_s, ram_re_s;
  logic [7:0]        ram_q;
  logic [23:0]       ext_full_s;

  jtkcpu_busresp_ram #(.AW(RAM_AW)) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .re   (ram_re_s),
    .addr (addr[RAM_AW-1:0]),
    .din  (cpu_dout),
    .q    (ram_q)
  );

  assign cache_hit_s = tag_match(cache_vld_r, cache_tag_r, addr);
  // Full CPU address of the outstanding external access, used as the cache tag.
  assign ext_full_s  = {EXT_START[23:EXT_AW], ext_addr_r};

  // Address decode; RAM is checked first so it wins on overlap.
  always_comb begin
    region_s = REG_NONE;
    if (addr[23:RAM_AW] == RAM_START[23:RAM_AW]) begin
      region_s = REG_RAM;
    end else if (addr[23:EXT_AW] == EXT_START[23:EXT_AW]) begin
      region_s = REG_EXT;
    end else begin
      region_s = REG_NONE;
    end
  end

  // Next-state and next-output logic of the responder FSM.
  always_comb begin
    state_s      = state_r;
    din_s        = din_r;
    sel_ram_s    = sel_ram_r;
    dtack_s      = dtack_r;
    ext_cs_s     = ext_cs_r;
    ext_we_s     = ext_we_r;
    ext_addr_s   = ext_addr_r;
    ext_din_s    = ext_din_r;
    unmapped_s   = 1'b0;
    timeout_s    = 1'b0;
    cnt_s        = cnt_r;
    cache_vld_s  = cache_vld_r;
    cache_tag_s  = cache_tag_r;
    cache_data_s = cache_data_r;
    ram_we_s     = 1'b0;
    ram_re_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cen) begin
          case (region_s)
            REG_RAM: begin
              if (we) begin
                ram_we_s = 1'b1;
              end else begin
                ram_re_s  = 1'b1;
                sel_ram_s = 1'b1;
              end
            end
            REG_EXT: begin
              if (!we && cache_hit_s) begin
                din_s     = cache_data_r;
                sel_ram_s = 1'b0;
              end else begin
                state_s    = ST_EXTWAIT;
                dtack_s    = 1'b0;
                ext_cs_s   = 1'b1;
                ext_we_s   = we;
                ext_addr_s = addr[EXT_AW-1:0];
                cnt_s      = '0;
                if (we) begin
                  ext_din_s = cpu_dout;
                  // Write-through: a stale cached copy of this byte must go.
                  if (cache_hit_s) begin
                    cache_vld_s = 1'b0;
                  end else begin
                    cache_vld_s = cache_vld_r;
                  end
                end else begin
                  ext_din_s = ext_din_r;
                end
              end
            end
            REG_NONE: begin
              unmapped_s = 1'b1;
              if (!we) begin
                din_s     = OPEN_BUS;
                sel_ram_s = 1'b0;
              end else begin
                din_s = din_r;
              end
            end
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXTWAIT: begin
        // ext_ok is checked before the counter so a coincident completion wins.
        if (ext_ok) begin
          state_s  = ST_DONE;
          ext_cs_s = 1'b0;
          ext_we_s = 1'b0;
          if (!ext_we_r) begin
            din_s        = ext_dout;
            sel_ram_s    = 1'b0;
            cache_vld_s  = 1'b1;
            cache_tag_s  = ext_full_s;
            cache_data_s = ext_dout;
          end else begin
            din_s = din_r;
          end
        end else if (cnt_r == TMO_LAST) begin
          state_s   = ST_DONE;
          ext_cs_s  = 1'b0;
          ext_we_s  = 1'b0;
          din_s     = OPEN_BUS;
          sel_ram_s = 1'b0;
          timeout_s = 1'b1;
        end else begin
          cnt_s = cnt_r + TMO_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        dtack_s = 1'b1;
      end
      default: begin
        state_s  = ST_IDLE;
        dtack_s  = 1'b1;
        ext_cs_s = 1'b0;
        ext_we_s = 1'b0;
      end
    endcase
  end

  // Register bank; rst abandons any external request and drops the cache entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      din_r        <= OPEN_BUS;
      sel_ram_r    <= 1'b0;
      dtack_r      <= 1'b1;
      ext_cs_r     <= 1'b0;
      ext_we_r     <= 1'b0;
      ext_addr_r   <= '0;
      ext_din_r    <= 8'h00;
      unmapped_r   <= 1'b0;
      timeout_r    <= 1'b0;
      cnt_r        <= '0;
      cache_vld_r  <= 1'b0;
      cache_tag_r  <= 24'h000000;
      cache_data_r <= 8'h00;
    end else begin
      state_r      <= state_s;
      din_r        <= din_s;
      sel_ram_r    <= sel_ram_s;
      dtack_r      <= dtack_s;
      ext_cs_r     <= ext_cs_s;
      ext_we_r     <= ext_we_s;
      ext_addr_r   <= ext_addr_s;
      ext_din_r    <= ext_din_s;
      unmapped_r   <= unmapped_s;
      timeout_r    <= timeout_s;
      cnt_r        <= cnt_s;
      cache_vld_r  <= cache_vld_s;
      cache_tag_r  <= cache_tag_s;
      cache_data_r <= cache_data_s;
    end
  end

  // RAM data comes straight from the RAM output register; the select is registered.
  assign cpu_din  = sel_ram_r ? ram_q : din_r;
  assign dtack    = dtack_r;
  assign ext_cs   = ext_cs_r;
  assign ext_we   = ext_we_r;
  assign ext_addr = ext_addr_r;
  assign ext_din  = ext_din_r;
  assign unmapped = unmapped_r;
  assign timeout  = timeout_r;

endmodule

// File: tb/tb_jtkcpu_busresp.sv
// Self-checking bench for jtkcpu_busresp: a vector table of CPU accesses with
// expected stall/handshake/pulse counts, a queue of expected read bytes, and
// hand-written reset sequences.
module tb_jtkcpu_busresp;

  logic        clk;
  logic        rst;
  logic        cen;
  logic [23:0] addr;
  logic        we;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        dtack;
  logic [19:0] ext_addr;
  logic        ext_cs;
  logic        ext_we;
  logic [7:0]  ext_din;
  logic [7:0]  ext_dout;
  logic        ext_ok;
  logic        unmapped;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        w;
    logic [23:0] a;
    logic [7:0]  d;
    int          lat;
    logic [7:0]  xd;
    logic [7:0]  exp_din;
    int          exp_stall;
    int          exp_cs;
    int          exp_unm;
    int          exp_tmo;
  } vec_t;

  typedef struct {
    int          stall;
    int          cs;
    int          we_cnt;
    int          unm;
    int          tmo;
    logic [19:0] xaddr;
    logic [7:0]  xdin;
    logic [7:0]  din;
    logic        dtack_end;
  } obs_t;

  localparam int NV = 20;
  vec_t       vt [0:NV-1];
  logic [7:0] exp_q [$];
  obs_t       o;

  jtkcpu_busresp dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .addr     (addr),
    .we       (we),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .dtack    (dtack),
    .ext_addr (ext_addr),
    .ext_cs   (ext_cs),
    .ext_we   (ext_we),
    .ext_din  (ext_din),
    .ext_dout (ext_dout),
    .ext_ok   (ext_ok),
    .unmapped (unmapped),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One CPU access starting at a negedge. The external side answers with ext_ok
  // driven at the lat-th negedge after the request (lat < 0: never answers).
  task automatic cpu_access(input logic w, input logic [23:0] a, input logic [7:0] d,
                            input int lat, input logic [7:0] xd, output obs_t ob);
    ob = '{default: 0};
    cen = 1'b1; we = w; addr = a; cpu_dout = d;
    @(negedge clk);
    cen = 1'b0;
    ob.xaddr = ext_addr;
    ob.xdin  = ext_din;
    for (int k = 0; k < 400; k++) begin
      if (ext_cs) ob.cs++;
      if (ext_cs && ext_we) ob.we_cnt++;
      if (unmapped) ob.unm++;
      if (timeout) ob.tmo++;
      if (dtack) break;
      ob.stall++;
      ext_dout = xd;
      ext_ok   = (k == lat);
      @(negedge clk);
    end
    ext_ok = 1'b0;
    ob.din       = cpu_din;
    ob.dtack_end = dtack;
    @(negedge clk);
    if (unmapped) ob.unm++;
    if (timeout) ob.tmo++;
  endtask

  initial begin
    //            w     addr          d      lat  xd     din    stall cs  unm tmo
    vt[0]  = '{1'b1, 24'h000010, 8'h5A, -1,  8'h00, 8'h00, 0,   0,  0,  0};
    vt[1]  = '{1'b0, 24'h000010, 8'h00, -1,  8'h00, 8'h5A, 0,   0,  0,  0};
    vt[2]  = '{1'b1, 24'h0007FF, 8'hA5, -1,  8'h00, 8'h00, 0,   0,  0,  0};
    vt[3]  = '{1'b0, 24'h0007FF, 8'h00, -1,  8'h00, 8'hA5, 0,   0,  0,  0};
    vt[4]  = '{1'b0, 24'h100234, 8'h00, 5,   8'hC3, 8'hC3, 7,   6,  0,  0};
    vt[5]  = '{1'b0, 24'h100234, 8'h00, -1,  8'h00, 8'hC3, 0,   0,  0,  0};
    vt[6]  = '{1'b1, 24'h100234, 8'h77, 2,   8'h00, 8'h00, 4,   3,  0,  0};
    vt[7]  = '{1'b0, 24'h100234, 8'h00, 0,   8'h77, 8'h77, 2,   1,  0,  0};
    vt[8]  = '{1'b0, 24'h300000, 8'h00, -1,  8'h00, 8'hFF, 0,   0,  1,  0};
    vt[9]  = '{1'b1, 24'h300000, 8'h12, -1,  8'h00, 8'h00, 0,   0,  1,  0};
    vt[10] = '{1'b0, 24'h1FFFFF, 8'h00, 3,   8'h3C, 8'h3C, 5,   4,  0,  0};
    vt[11] = '{1'b1, 24'h100000, 8'h11, 1,   8'h00, 8'h00, 3,   2,  0,  0};
    vt[12] = '{1'b0, 24'h1FFFFF, 8'h00, -1,  8'h00, 8'h3C, 0,   0,  0,  0};
    vt[13] = '{1'b0, 24'h0FFFFF, 8'h00, -1,  8'h00, 8'hFF, 0,   0,  1,  0};
    vt[14] = '{1'b0, 24'h000800, 8'h00, -1,  8'h00, 8'hFF, 0,   0,  1,  0};
    vt[15] = '{1'b0, 24'h000010, 8'h00, -1,  8'h00, 8'h5A, 0,   0,  0,  0};
    vt[16] = '{1'b0, 24'h100500, 8'h00, -1,  8'h00, 8'hFF, 256, 255, 0, 1};
    vt[17] = '{1'b0, 24'h100500, 8'h00, 1,   8'h99, 8'h99, 3,   2,  0,  0};
    vt[18] = '{1'b0, 24'h100501, 8'h00, 254, 8'h6D, 8'h6D, 256, 255, 0, 0};
    vt[19] = '{1'b0, 24'h100501, 8'h00, -1,  8'h00, 8'h6D, 0,   0,  0,  0};

    rst = 1'b1; cen = 1'b0; addr = 24'h000000; we = 1'b0; cpu_dout = 8'h00;
    ext_dout = 8'h00; ext_ok = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset cpu_din", {24'h0, cpu_din}, 32'h000000FF);
    chk("reset dtack", {31'h0, dtack}, 32'h1);
    chk("reset ext_cs", {31'h0, ext_cs}, 32'h0);
    chk("reset ext_we", {31'h0, ext_we}, 32'h0);
    chk("reset ext_addr", {12'h0, ext_addr}, 32'h0);
    chk("reset ext_din", {24'h0, ext_din}, 32'h0);
    chk("reset unmapped", {31'h0, unmapped}, 32'h0);
    chk("reset timeout", {31'h0, timeout}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (!vt[i].w) exp_q.push_back(vt[i].exp_din);
      cpu_access(vt[i].w, vt[i].a, vt[i].d, vt[i].lat, vt[i].xd, o);
      chk($sformatf("v%0d dtack_return", i), {31'h0, o.dtack_end}, 32'h1);
      chk($sformatf("v%0d stall", i), o.stall, vt[i].exp_stall);
      chk($sformatf("v%0d ext_cs_cycles", i), o.cs, vt[i].exp_cs);
      chk($sformatf("v%0d unmapped_pulses", i), o.unm, vt[i].exp_unm);
      chk($sformatf("v%0d timeout_pulses", i), o.tmo, vt[i].exp_tmo);
      if (vt[i].exp_cs > 0) begin
        chk($sformatf("v%0d ext_addr", i), {12'h0, o.xaddr}, {12'h0, vt[i].a[19:0]});
        chk($sformatf("v%0d ext_we_cycles", i), o.we_cnt, vt[i].w ? vt[i].exp_cs : 0);
        if (vt[i].w) chk($sformatf("v%0d ext_din", i), {24'h0, o.xdin}, {24'h0, vt[i].d});
      end
      if (!vt[i].w) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL v%0d scoreboard: queue empty, expected one entry", i);
        end else begin
          chk($sformatf("v%0d cpu_din", i), {24'h0, o.din}, {24'h0, exp_q.pop_front()});
        end
      end
    end

    // Reset while waiting on the external side; a late ext_ok must be ignored.
    cen = 1'b1; we = 1'b0; addr = 24'h100600;
    @(negedge clk);
    cen = 1'b0;
    chk("midrst pre ext_cs", {31'h0, ext_cs}, 32'h1);
    chk("midrst pre dtack", {31'h0, dtack}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst ext_cs", {31'h0, ext_cs}, 32'h0);
    chk("midrst dtack", {31'h0, dtack}, 32'h1);
    chk("midrst cpu_din", {24'h0, cpu_din}, 32'h000000FF);
    chk("midrst ext_we", {31'h0, ext_we}, 32'h0);
    rst = 1'b0; ext_ok = 1'b1; ext_dout = 8'hEE;
    @(negedge clk);
    ext_ok = 1'b0;
    @(negedge clk);
    chk("late ext_ok dtack", {31'h0, dtack}, 32'h1);
    chk("late ext_ok cpu_din", {24'h0, cpu_din}, 32'h000000FF);
    chk("late ext_ok ext_cs", {31'h0, ext_cs}, 32'h0);

    // The entry cached before reset must miss now.
    exp_q.push_back(8'h42);
    cpu_access(1'b0, 24'h100501, 8'h00, 1, 8'h42, o);
    chk("postrst ext_cs_cycles", o.cs, 2);
    chk("postrst stall", o.stall, 3);
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL postrst scoreboard: queue empty, expected one entry");
    end else begin
      chk("postrst cpu_din", {24'h0, o.din}, {24'h0, exp_q.pop_front()});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtkcpu_busresp.md
Name: jtkcpu_busresp

Overview:
- Bus responder sitting on the far side of the jtkcpu memory bus: consumes the CPU's addr/we/dout and returns din plus dtack.
- Decodes three regions: internal synchronous RAM (zero-wait), external memory reached through a req/ok handshake (SDRAM/ROM controller), and unmapped space.
- Inserts wait states by pulling dtack low until external data is ready. Keeps a one-entry read cache so the CPU re-presenting the same address across cen ticks costs no extra fetch.

Parameters:
- RAM_AW, 11, internal RAM address width (2^RAM_AW bytes).
- RAM_START, 24'h000000, RAM base; match on addr[23:RAM_AW].
- EXT_AW, 20, external window address width.
- EXT_START, 24'h100000, external base; match on addr[23:EXT_AW].
- TIMEOUT, 255, max clk cycles waiting for ext_ok before aborting (8-bit counter).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cen  in  1  CPU bus-cycle enable (CPU cen_out)
- addr  in  24  CPU address
- we  in  1  CPU write enable
- cpu_dout  in  8  write data from CPU
- cpu_din  out  8  read data to CPU
- dtack  out  1  data acknowledge; low stalls the CPU
- ext_addr  out  EXT_AW  external address (addr[EXT_AW-1:0] latched)
- ext_cs  out  1  external request, held until ext_ok
- ext_we  out  1  external write
- ext_din  out  8  external write data
- ext_dout  in  8  external read data
- ext_ok  in  1  external completion, one-cycle pulse
- unmapped  out  1  one-cycle pulse on an access to unmapped space
- timeout  out  1  one-cycle pulse on an aborted external access

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - cpu_din=8'hFF, dtack=1, ext_cs=0, ext_we=0, ext_addr=0, ext_din=0, unmapped=0, timeout=0.
  - Cache invalid; FSM=IDLE; timeout counter=0.
- Decode: RAM if addr[23:RAM_AW]==RAM_START[23:RAM_AW]. Else EXT if addr[23:EXT_AW]==EXT_START[23:EXT_AW]. Else UNMAPPED. RAM wins on overlap.
- FSM states: IDLE, EXTWAIT, DONE. Requests are sampled only when cen=1 in IDLE.
- RAM read: RAM read at addr; cpu_din valid the next clk; dtack stays 1.
- RAM write: byte written on that clk; dtack stays 1.
- EXT read, cache hit (cache valid and tag==addr): cpu_din <= cached byte next clk; dtack stays 1; no ext_cs.
- EXT read, miss:
  - Next clk: dtack=0, ext_cs=1, ext_we=0, ext_addr latched; go to EXTWAIT.
  - On ext_ok: cpu_din<=ext_dout, cache<=(addr,ext_dout), ext_cs=0; go to DONE.
  - DONE lasts 1 clk, then dtack=1 and IDLE. Minimum stall = 2 clk after ext_ok assertion.
- EXT write (always write-through):
  - ext_cs=1, ext_we=1, ext_din=cpu_dout; dtack=0 until ext_ok, then DONE.
  - Invalidate the cache if its tag==addr; otherwise the cache is unchanged.
- UNMAPPED: cpu_din=8'hFF (read), write ignored, dtack stays 1, unmapped pulses 1 clk.
- Timeout:
  - Counter clears on entry to EXTWAIT and increments each clk there.
  - At TIMEOUT: ext_cs=0, cpu_din=8'hFF, timeout pulses, go to DONE. Cache not updated.
  - An ext_ok on the same clk as the timeout wins over the timeout.
- ext_ok while not in EXTWAIT is ignored.
- cen is ignored outside IDLE; the CPU holds addr/we while dtack=0.
- rst mid-access returns all outputs to reset values on that clk, abandons ext_cs immediately and invalidates the cache.

Decomposition:
- Region enum {REG_RAM, REG_EXT, REG_NONE} and FSM state encoding go in jtkcpu_pkg.
- One sub-module: jtkcpu_busresp_ram, a single-port synchronous RAM (RAM_AW x 8, registered read, write-enable).

Test Plan:
- Reset then RAM write 8'h5A @24'h000010 followed by read @24'h000010 -> cpu_din=8'h5A one clk after cen, dtack never low.
- EXT read @24'h100234, ext_ok returns 8'hC3 after 5 clk -> dtack low for 7 clk, ext_addr=20'h00234, cpu_din=8'hC3; a repeated read of the same address gives no ext_cs and dtack stays 1.
- EXT write 8'h77 @24'h100234 after the cached read -> ext_we=1, ext_din=8'h77; the next read of 24'h100234 re-issues ext_cs (cache invalidated).
- Read @24'h300000 -> cpu_din=8'hFF, unmapped single pulse, dtack=1.
- EXT read with ext_ok never asserted -> after 255 clk timeout pulses, cpu_din=8'hFF, dtack returns 1; a follow-up read misses the cache.
- Assert rst while in EXTWAIT -> same clk yields ext_cs=0, dtack=1; ext_ok arriving later is ignored and causes no cache update.
